// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : J/K-side controller for a WIDTH-bit bank of master-slave JK
//            flip-flops.
//
//            The block keeps a shadow copy S of the count. It drives per-bit
//            J/K excitation so that the bank steps through a modulo-MODULUS
//            up/down sequence. It also reads the bank's Q/Qc back and raises
//            a sticky error on any divergence.
//
// Ports    : clk        - common clock. The bank master captures on posedge
//                         and the bank slave updates on negedge.
//            CLR_n      - asynchronous active-low reset
//            en, up     - step the count by one; up=1 counts up, up=0 down
//            load       - load load_val (takes priority over en)
//            load_val   - value to load; values >= MODULUS are rejected
//            clear_err  - leave the error state and re-initialise the bank
//            Q, Qc      - bank true / complement outputs (read-back)
//            J, K       - per-bit excitation to the bank (never J=K=1)
//            bank_clr   - synchronous clear to the bank
//            count      - shadow state S
//            wrap       - one-cycle pulse after a modulus wrap
//            load_err   - one-cycle pulse after a rejected load
//            err        - sticky read-back mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             CLR_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_err,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] Qc,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             bank_clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             load_err,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Highest legal state. When MODULUS = 2^WIDTH this is all-ones, so S+1
  // wraps naturally. The explicit compare still raises the wrap pulse.
  localparam logic [WIDTH-1:0] MAX_S   = WIDTH'(MODULUS - 1);
  // The load range check is done one bit wider, so that MODULUS = 2^WIDTH
  // accepts every load value.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s_q, s_nxt;
  logic [WIDTH-1:0] target;
  logic             err_q, err_nxt;
  logic             wrap_q, wrap_nxt;
  logic             lerr_q, lerr_nxt;
  logic             ok;
  logic             load_ok;

  // Q still shows S from before the current update. The slave only moves on
  // the negedge after the capturing posedge, so at a posedge it must equal S.
  assign ok      = (Q == s_q) && (Qc == ~s_q);
  assign load_ok = ({1'b0, load_val} < MOD_EXT);

  // --------------------------------------------------------------------------
  // Next state / target. target == s_q means "hold". It yields J=K=0 below,
  // so every non-RUN state and every rejected or mismatched cycle leaves
  // target at s_q.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    s_nxt     = s_q;
    target    = s_q;
    err_nxt   = err_q;
    wrap_nxt  = 1'b0;
    lerr_nxt  = 1'b0;

    case (state)
      ST_INIT: begin
        state_nxt = ST_SYNC;
        s_nxt     = '0;
      end

      ST_SYNC: begin
        if (ok && (s_q == '0)) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_ERR;
          err_nxt   = 1'b1;
        end
      end

      ST_RUN: begin
        if (!ok) begin
          state_nxt = ST_ERR;
          err_nxt   = 1'b1;
        end else if (load) begin
          // A rejected load also swallows en for this cycle.
          if (load_ok) begin
            target = load_val;
          end else begin
            lerr_nxt = 1'b1;
          end
        end else if (en) begin
          if (up) begin
            if (s_q == MAX_S) begin
              target   = '0;
              wrap_nxt = 1'b1;
            end else begin
              target = s_q + WIDTH'(1);
            end
          end else begin
            if (s_q == '0) begin
              target   = MAX_S;
              wrap_nxt = 1'b1;
            end else begin
              target = s_q - WIDTH'(1);
            end
          end
        end
        s_nxt = target;
      end

      ST_ERR: begin
        if (clear_err) begin
          state_nxt = ST_INIT;
          err_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_INIT;
        s_nxt     = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Excitation: a bit at 0 is set with J=n, K=0. A bit at 1 is reset with
  // J=0, K=~n. J and K can therefore never both be high on one bit.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_excite
      assign J[gi] = ~s_q[gi] &  target[gi];
      assign K[gi] =  s_q[gi] & ~target[gi];
    end
  endgenerate

  assign bank_clr = (state == ST_INIT);
  assign count    = s_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;
  assign err      = err_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state  <= ST_INIT;
      s_q    <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      s_q    <= s_nxt;
      err_q  <= err_nxt;
      wrap_q <= wrap_nxt;
      lerr_q <= lerr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_driver
// Purpose  : Self-checking bench for jk_bank_driver.
//            - A behavioural master-slave JK bank closes the loop. It supports
//              injectable read-back faults.
//            - A modular-arithmetic reference model predicts the excitation
//              and the registered outputs for every cycle, and queues them.
//            - A monitor pops the expectations and compares them with the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  localparam int P_INIT = 0;
  localparam int P_SYNC = 1;
  localparam int P_RUN  = 2;
  localparam int P_ERR  = 3;

  logic             clk = 1'b0;
  logic             CLR_n = 1'b0;
  logic             en = 1'b0;
  logic             up = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qc;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             bank_clr;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             load_err;
  logic             err;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk(clk), .CLR_n(CLR_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .clear_err(clear_err), .Q(Q), .Qc(Qc),
    .J(J), .K(K), .bank_clr(bank_clr), .count(count), .wrap(wrap),
    .load_err(load_err), .err(err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural JK bank.
  // - The master captures at posedge, using J/K/clr sampled just before it.
  // - The slave copies the master at negedge.
  // - stuck_mask forces Q bits high; qc_eq0 forces Qc[0] equal to Q[0].
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] master = '0;
  logic [WIDTH-1:0] slave = '0;
  logic [WIDTH-1:0] stuck_mask = '0;
  logic             qc_eq0 = 1'b0;
  logic [WIDTH-1:0] pend_stuck = '0;
  logic             pend_qceq = 1'b0;

  always_comb begin
    Q  = slave | stuck_mask;
    Qc = ~slave;
    if (qc_eq0) Qc[0] = Q[0];
  end

  initial begin
    logic [WIDTH-1:0] sj, sk;
    logic             sc;
    forever begin
      @(negedge clk);
      slave = master;
      #4;
      sj = J; sk = K; sc = bank_clr;
      @(posedge clk);
      if (sc) master = '0;
      else    master = (sj & ~master) | (~sk & master);
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard queues
  //   jk_q  : {J, K, bank_clr}                 expected just before posedge
  //   out_q : {count, wrap, load_err, err, bank_clr} expected after posedge
  // --------------------------------------------------------------------------
  logic [2*WIDTH:0]  jk_q[$];
  logic [WIDTH+3:0]  out_q[$];

  initial begin
    logic [2*WIDTH:0] ej;
    logic [WIDTH+3:0] eo;
    forever begin
      @(negedge clk); #4;
      if (jk_q.size() > 0) begin
        ej = jk_q.pop_front();
        chk("J",         32'(J),        32'(ej[2*WIDTH:WIDTH+1]));
        chk("K",         32'(K),        32'(ej[WIDTH:1]));
        chk("bclr_pre",  32'(bank_clr), 32'(ej[0]));
        chk("no_toggle", 32'(J & K),    32'd0);
      end
      @(posedge clk); #1;
      if (out_q.size() > 0) begin
        eo = out_q.pop_front();
        chk("count",    32'(count),    32'(eo[WIDTH+3:4]));
        chk("wrap",     32'(wrap),     32'(eo[3]));
        chk("load_err", 32'(load_err), 32'(eo[2]));
        chk("err",      32'(err),      32'(eo[1]));
        chk("bclr",     32'(bank_clr), 32'(eo[0]));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: phase + count, advanced with modular arithmetic.
  // --------------------------------------------------------------------------
  int m_phase = P_INIT;
  int m_s     = 0;
  bit m_err   = 1'b0;

  task automatic step(input bit i_en, input bit i_up, input bit i_load,
                      input int i_lv, input bit i_clr, input bit i_rst_n);
    int               tgt, ns, nph;
    bit               w, le, nerr, ok, falling;
    logic [WIDTH-1:0] sv, tv, ej, ek;
    @(negedge clk); #1;
    stuck_mask = pend_stuck;
    qc_eq0     = pend_qceq;
    en = i_en; up = i_up; load = i_load; load_val = WIDTH'(i_lv); clear_err = i_clr;
    falling = CLR_n && !i_rst_n;
    CLR_n   = i_rst_n;
    #1;
    if (falling) begin
      chk("async_count", 32'(count),    32'd0);
      chk("async_bclr",  32'(bank_clr), 32'd1);
      chk("async_err",   32'(err),      32'd0);
      chk("async_J",     32'(J),        32'd0);
      chk("async_K",     32'(K),        32'd0);
    end

    if (!i_rst_n) begin
      m_phase = P_INIT;
      m_s     = 0;
      m_err   = 1'b0;
    end
    sv  = WIDTH'(m_s);
    ok  = (Q == sv) && (Qc == ~sv);
    tgt = m_s; ns = m_s; nph = m_phase; nerr = m_err; w = 1'b0; le = 1'b0;

    if (!i_rst_n) begin
      nph = P_INIT; ns = 0;
    end else begin
      case (m_phase)
        P_INIT: begin nph = P_SYNC; ns = 0; end
        P_SYNC: if (ok) nph = P_RUN; else begin nph = P_ERR; nerr = 1'b1; end
        P_RUN: begin
          if (!ok) begin
            nph = P_ERR; nerr = 1'b1;
          end else if (i_load) begin
            if (i_lv < MODULUS) tgt = i_lv;
            else                le  = 1'b1;
          end else if (i_en) begin
            if (i_up) begin
              tgt = (m_s + 1) % MODULUS;
              w   = (m_s + 1 == MODULUS);
            end else begin
              tgt = (m_s + MODULUS - 1) % MODULUS;
              w   = (m_s == 0);
            end
          end
          ns = tgt;
        end
        default: if (i_clr) begin nph = P_INIT; nerr = 1'b0; end
      endcase
    end

    // Excitation rule, bit by bit: from 0 set with J=n; from 1 reset with K=~n.
    tv = WIDTH'(tgt);
    for (int b = 0; b < WIDTH; b++) begin
      if (sv[b] == 1'b0) begin ej[b] = tv[b]; ek[b] = 1'b0;   end
      else               begin ej[b] = 1'b0;  ek[b] = ~tv[b]; end
    end
    jk_q.push_back({ej, ek, (m_phase == P_INIT)});
    out_q.push_back({WIDTH'(ns), w, le, nerr, (nph == P_INIT)});
    m_s = ns; m_phase = nph; m_err = nerr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset, then INIT -> SYNC -> RUN.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(3);

    // Count up 12 times: 1..9, 0 (wrap), 1, 2.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 1);

    // Down-wrap from 0, load beats en, rejected load.
    step(0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 5, 0, 1);
    step(1, 1, 1, 12, 0, 1);
    step(0, 0, 1, 9, 0, 1);
    step(0, 0, 1, 15, 0, 1);

    // Q[2] stuck-at-1 while at 3.
    step(0, 0, 1, 3, 0, 1);
    pend_stuck = 4'b0100;
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 1, 2, 0, 1);
    pend_stuck = '0;
    step(0, 0, 0, 0, 1, 1);
    idle(3);

    // Qc[0] == Q[0].
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    pend_qceq = 1'b1;
    step(1, 1, 0, 0, 0, 1);
    pend_qceq = 1'b0;
    step(1, 1, 0, 0, 1, 1);
    idle(3);

    // Asynchronous reset in mid-count at 6.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(3);

    // Random traffic with occasional read-back faults.
    for (int i = 0; i < 300; i++) begin
      pend_stuck = ($urandom_range(0, 29) == 0) ? WIDTH'($urandom_range(1, 15)) : '0;
      pend_qceq  = ($urandom_range(0, 39) == 0);
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
    end
    pend_stuck = '0;
    pend_qceq  = 1'b0;
    idle(2);

    @(posedge clk); #3;
    chk("jk_queue_drained",  32'(jk_q.size()),  32'd0);
    chk("out_queue_drained", 32'(out_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Controller for the J/K side of a WIDTH-bit bank of master-slave JK flip-flops.
- Keeps a shadow copy of the count and drives per-bit J/K excitation so the bank steps through a modulo-MODULUS up/down sequence.
- Reads the bank's Q/Qc back and flags any divergence.
- Sits between control logic and the flip-flop bank; the bank supplies Q and Qc and receives J, K and a synchronous clear.

Parameters:
WIDTH, 4, bits in the JK bank and in count/load values
MODULUS, 10, count sequence length (2..2^WIDTH); legal states are 0..MODULUS-1

Ports:
clk  input  1  clock; same clock as the JK bank (bank master captures on posedge, slave updates on negedge)
CLR_n  input  1  asynchronous active-low reset
en  input  1  step the count by one this cycle
up  input  1  1 = count up, 0 = count down
load  input  1  load load_val this cycle (priority over en)
load_val  input  WIDTH  value to load
clear_err  input  1  leave ERR and re-initialise
Q  input  WIDTH  bank true outputs
Qc  input  WIDTH  bank complement outputs
J  output  WIDTH  per-bit J excitation
K  output  WIDTH  per-bit K excitation
bank_clr  output  1  synchronous clear to bank (high = clear at next posedge)
count  output  WIDTH  shadow state S
wrap  output  1  one-cycle pulse on modulus wrap
load_err  output  1  one-cycle pulse when a load is rejected
err  output  1  sticky mismatch flag

Behaviour:
- Reset (CLR_n=0, asynchronous):
  - state=INIT, S=0, wrap=0, load_err=0, err=0.
  - Outputs: J=0, K=0, bank_clr=1.
- Excitation rule, per bit, for target n from current s:
  - s=0 drives J=n, K=0.
  - s=1 drives J=0, K=~n.
  - Hold drives J=K=0.
  - The toggle combination J=K=1 is never driven.
- J, K and bank_clr are combinational from state, S, en, up, load and load_val. They must be stable before each posedge.
- Check at every posedge in SYNC and RUN: ok = (Q==S) and (Qc==~S). Q reflects the S value from before the current update, because the bank slave updates on the negedge after the capturing posedge.
- States:
  - INIT: bank_clr=1, J=K=0. After one posedge, go to SYNC.
  - SYNC: bank_clr=0, J=K=0. On posedge: if ok with S=0, go to RUN; else go to ERR and set err=1.
  - RUN:
    - Evaluation priority: mismatch > load > en > hold.
    - Mismatch (!ok): go to ERR, set err=1, S unchanged, no wrap/load_err pulse, J=K=0 from that cycle on.
    - load with load_val <= MODULUS-1: excitation targets load_val; S <= load_val at posedge; no wrap.
    - load with load_val >= MODULUS: load_err pulses for one cycle after the posedge; excitation is hold; S unchanged; en ignored that cycle.
    - en, up=1: target = (S==MODULUS-1) ? 0 : S+1. Wrap case pulses wrap for one cycle.
    - en, up=0: target = (S==0) ? MODULUS-1 : S-1. Wrap case pulses wrap.
    - Neither load nor en: hold; S unchanged.
  - ERR: J=K=0, bank_clr=0, S frozen, err=1. clear_err at posedge goes to INIT and clears err. Other inputs are ignored.
- Arithmetic:
  - All math is WIDTH bits.
  - MODULUS = 2^WIDTH wraps naturally; the explicit compare must still produce the wrap pulse.
- Outputs:
  - wrap and load_err are registered and high for exactly the cycle after the causing posedge.
  - count = S.
- Reset mid-operation: outputs return to reset values immediately, asynchronously; the INIT sequence repeats on release.
- Latency:
  - Excitation presented in cycle N is captured by the bank at posedge N.
  - Q shows the new value after negedge N.
  - S updates at posedge N.
  - The check of that value happens at posedge N+1.

Test Plan:
- Reset release, bank model clean -> bank_clr=1 for exactly 1 cycle, then SYNC, then RUN; count=0; err=0; J=K=0 throughout.
- en=1, up=1, 12 cycles, MODULUS=10 -> count 1..9,0,1,2; wrap high only in the cycle after 9 goes to 0; J/K per bit match the excitation rule (e.g. 7 to 8 gives J=4'b1000, K=4'b0111); never J&K.
- en=1, up=0 from 0 -> count 9 with wrap pulse; load=1, load_val=5 together with en=1 -> count 5 (load wins); load_val=12 -> load_err pulse, count held, J=K=0.
- Bank model forces Q[2] stuck-at-1 while in RUN -> at the next posedge err=1, state ERR, J=K=0, count frozen; clear_err=1 -> INIT, bank_clr pulse, err=0.
- Bank model makes Q and Qc equal on bit 0 -> ERR within one posedge.
- CLR_n asserted low mid-count at count=6 -> count=0, bank_clr=1, err=0 immediately without a clock edge; normal INIT sequence after release.
